mux_pipe_stage: RTL and testbench

- Parametrised N:1 data selector with a registered, valid/ready-handshaked output stage.
- Generalises the plain 32-bit 2:1 operand mux: width and input count are configurable, out-of-range selects are flagged, and the stage absorbs downstream stalls through a one-entry skid buffer.
- Sits in the CPU datapath wherever a selected operand crosses a pipeline boundary, e.g. ALU source select and writeback select.

---
 rtl/mux_pipe_stage.sv | 133 +++++++++++++
 tb/tb_mux_pipe_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_stage.sv
// ---------------------------------------------------------------------------
// mux_pipe_stage
//
// Purpose:
//   Parametrised N:1 data selector feeding a registered valid/ready output
//   stage. A one-entry skid buffer absorbs a downstream stall so that
//   in_ready never depends combinationally on out_ready.
//
// Parameters:
//   WIDTH   data bits per input channel
//   NUM_IN  number of input channels (>= 2)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_data      packed channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel       channel index for this beat
//   in_valid     upstream beat present
//   in_ready     stage can accept a beat (registered, = ~skid_valid)
//   out_data     selected, registered data
//   out_sel_err  beat was produced from an out-of-range select
//   out_valid    output beat present
//   out_ready    downstream accepts the beat
// ---------------------------------------------------------------------------
module mux_pipe_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

    logic [WIDTH-1:0] sel_data_s;
    logic             sel_err_s;

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q,  main_err_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q,  skid_err_d;
    logic             skid_valid_q, skid_valid_d;

    logic             in_xfer_s;
    logic             main_free_s;

    // Channel select: out-of-range indices match no channel, so data is zero.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            sel_data_s = (in_sel == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH]
                                               : sel_data_s;
        end
        sel_err_s = ({1'b0, in_sel} >= NUM_IN_L);
    end

    // Next-state for main register and skid entry.
    always_comb begin
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        skid_valid_d = skid_valid_q;

        // Input can only be taken while the skid is empty.
        in_xfer_s   = in_valid & ~skid_valid_q;
        // Main can take a new beat when empty or when its beat leaves now.
        main_free_s = ~main_valid_q | out_ready;

        if (main_free_s) begin
            if (skid_valid_q) begin
                // Oldest buffered beat goes first to preserve ordering.
                main_data_d  = skid_data_q;
                main_err_d   = skid_err_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer_s) begin
                main_data_d  = sel_data_s;
                main_err_d   = sel_err_s;
                main_valid_d = 1'b1;
            end else begin
                // Data is left in place; only the valid flag drops.
                main_valid_d = 1'b0;
            end
        end else begin
            if (in_xfer_s) begin
                skid_data_d  = sel_data_s;
                skid_err_d   = sel_err_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers with synchronous reset overriding all transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= {WIDTH{1'b0}};
            main_err_q   <= 1'b0;
            main_valid_q <= 1'b0;
            skid_data_q  <= {WIDTH{1'b0}};
            skid_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = ~skid_valid_q;
    assign out_data    = main_data_q;
    assign out_sel_err = main_err_q;
    assign out_valid   = main_valid_q;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_mux_pipe_stage
//
// Directed bench for mux_pipe_stage. Two instances share control signals:
// dut4 (NUM_IN=4) covers select/stream/stall/stability/reset, dut3
// (NUM_IN=3) covers the out-of-range select. Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_mux_pipe_stage;

    localparam logic [31:0] CH0 = 32'h1111_1111;
    localparam logic [31:0] CH1 = 32'h2222_2222;
    localparam logic [31:0] CH2 = 32'h3333_3333;
    localparam logic [31:0] CH3 = 32'h4444_4444;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready4, out_valid4, out_sel_err4;
    logic [31:0]  out_data4;
    logic         in_ready3, out_valid3, out_sel_err3;
    logic [31:0]  out_data3;

    logic [31:0]  chan [4];

    int checks;
    int failures;

    mux_pipe_stage #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .out_data   (out_data4),
        .out_sel_err(out_sel_err4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready)
    );

    mux_pipe_stage #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data[95:0]),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready3),
        .out_data   (out_data3),
        .out_sel_err(out_sel_err3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chan[0] = CH0; chan[1] = CH1; chan[2] = CH2; chan[3] = CH3;
        in_data   = {CH3, CH2, CH1, CH0};
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        chk("rst_out_data", out_data4, 32'd0);
        chk("rst_out_err", {31'd0, out_sel_err4}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready4}, 32'd1);

        // Basic select: channel 2, one-cycle latency, then idle
        in_sel = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("basic_valid", {31'd0, out_valid4}, 32'd1);
        chk("basic_data", out_data4, CH2);
        chk("basic_err", {31'd0, out_sel_err4}, 32'd0);
        step();
        chk("basic_valid_drop", {31'd0, out_valid4}, 32'd0);

        // Streaming: 8 back-to-back beats, one per cycle
        for (int i = 0; i < 8; i++) begin
            in_sel = 2'(i % 4); in_valid = 1'b1;
            step();
            chk("stream_data", out_data4, chan[i % 4]);
            chk("stream_valid", {31'd0, out_valid4}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready4}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", {31'd0, out_valid4}, 32'd0);

        // Stall and skid
        out_ready = 1'b0;
        in_sel = 2'd0; in_valid = 1'b1;
        step();
        chk("stall_first_ready", {31'd0, in_ready4}, 32'd1);
        in_sel = 2'd1;
        step();
        chk("stall_main_data", out_data4, CH0);
        chk("stall_in_ready", {31'd0, in_ready4}, 32'd0);
        in_sel = 2'd3;
        step();
        chk("stall_third_blocked", {31'd0, in_ready4}, 32'd0);
        chk("stall_main_hold", out_data4, CH0);
        out_ready = 1'b1;
        step();
        chk("drain_skid_data", out_data4, CH1);
        chk("drain_in_ready", {31'd0, in_ready4}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("drain_third_data", out_data4, CH3);
        chk("drain_third_valid", {31'd0, out_valid4}, 32'd1);
        step();
        chk("drain_empty", {31'd0, out_valid4}, 32'd0);

        // Output stability under stall while inputs toggle
        out_ready = 1'b0;
        in_sel = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_sel  = 2'(i);
            in_data = ~in_data;
            step();
            chk("stable_data", out_data4, CH2);
            chk("stable_err", {31'd0, out_sel_err4}, 32'd0);
            chk("stable_valid", {31'd0, out_valid4}, 32'd1);
        end
        in_data   = {CH3, CH2, CH1, CH0};
        out_ready = 1'b1;
        step();
        chk("stable_release", {31'd0, out_valid4}, 32'd0);

        // Out-of-range select on the 3-input instance
        in_sel = 2'd3; in_valid = 1'b1;
        step();
        chk("oor_data", out_data3, 32'd0);
        chk("oor_err", {31'd0, out_sel_err3}, 32'd1);
        chk("oor_valid", {31'd0, out_valid3}, 32'd1);
        chk("inrange4_err", {31'd0, out_sel_err4}, 32'd0);
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        chk("after_oor_data", out_data3, CH1);
        chk("after_oor_err", {31'd0, out_sel_err3}, 32'd0);
        step();

        // Reset with main and skid both full
        out_ready = 1'b0;
        in_sel = 2'd0; in_valid = 1'b1;
        step();
        in_sel = 2'd1;
        step();
        chk("pre_rst_in_ready", {31'd0, in_ready4}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", {31'd0, out_valid4}, 32'd0);
        chk("midrst_data", out_data4, 32'd0);
        chk("midrst_err", {31'd0, out_sel_err4}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready4}, 32'd1);
        chk("midrst_in_ready3", {31'd0, in_ready3}, 32'd1);
        in_sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_data", out_data4, CH3);
        chk("post_rst_valid", {31'd0, out_valid4}, 32'd1);
        step();
        chk("post_rst_empty", {31'd0, out_valid4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
